// File: rtl/zigbee_cordic_arbiter_if.sv
// Bundles the requester-side handshake, the CORDIC core link and the per-requester results.
// master: the arbiter; slave: requesters plus core.
interface zigbee_cordic_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int IQ_SIZE = 5,
  parameter int W_SIZE  = 6
);
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*IQ_SIZE-1:0] req_ibb;
  logic [NUM_REQ*IQ_SIZE-1:0] req_qbb;
  logic [IQ_SIZE-1:0]         cor_ibb;
  logic [IQ_SIZE-1:0]         cor_qbb;
  logic                       cor_ivalid;
  logic [W_SIZE-1:0]          cor_wout;
  logic                       cor_ovalid;
  logic [NUM_REQ*W_SIZE-1:0]  res_w;
  logic [NUM_REQ-1:0]         res_valid;

  modport master (
    input  req_valid, req_ibb, req_qbb, cor_wout, cor_ovalid,
    output req_ready, cor_ibb, cor_qbb, cor_ivalid, res_w, res_valid
  );

  modport slave (
    output req_valid, req_ibb, req_qbb, cor_wout, cor_ovalid,
    input  req_ready, cor_ibb, cor_qbb, cor_ivalid, res_w, res_valid
  );
endinterface

// File: rtl/zigbee_cordic_arbiter.sv
// Round-robin sharing of one pipelined CORDIC phase core between NUM_REQ I/Q requesters,
// with a tag pipe that routes each returned phase back to its owner.
module zigbee_cordic_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int IQ_SIZE    = 5,
  parameter int W_SIZE     = 6,
  parameter int CORDIC_LAT = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  zigbee_cordic_arbiter_if.master bus,
  output logic                   busy,
  output logic                   err
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef logic [IDX_W-1:0] idx_t;

  idx_t                  rr_ptr_reg;
  logic [NUM_REQ-1:0]    grant;
  idx_t                  grant_idx;
  logic                  grant_any;

  logic [IQ_SIZE-1:0]    cor_ibb_reg;
  logic [IQ_SIZE-1:0]    cor_qbb_reg;
  logic                  cor_ivalid_reg;
  idx_t                  cor_idx_reg;

  logic [CORDIC_LAT-1:0] tag_vld_reg;
  idx_t                  tag_idx_reg [CORDIC_LAT];
  logic                  last_vld;
  idx_t                  last_idx;

  logic [W_SIZE-1:0]     res_w_reg [NUM_REQ];
  logic [NUM_REQ*W_SIZE-1:0] res_w_flat;
  logic [NUM_REQ-1:0]    res_hit;
  logic [NUM_REQ-1:0]    res_valid_reg;
  logic                  err_reg;

  function automatic int scan_idx(input idx_t ptr, input int off);
    return (int'(ptr) + off) % NUM_REQ;
  endfunction

  // Scan starts one past the last winner; req_ready is held low while reset is asserted.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    if (enable && reset_n) begin
      for (int off = 1; off <= NUM_REQ; off++) begin
        if (!grant_any && bus.req_valid[scan_idx(rr_ptr_reg, off)]) begin
          grant[scan_idx(rr_ptr_reg, off)] = 1'b1;
          grant_idx = idx_t'(scan_idx(rr_ptr_reg, off));
          grant_any = 1'b1;
        end
      end
    end
  end

  assign bus.req_ready = grant;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_reg     <= idx_t'(NUM_REQ - 1);
      cor_ibb_reg    <= '0;
      cor_qbb_reg    <= '0;
      cor_ivalid_reg <= 1'b0;
      cor_idx_reg    <= '0;
    end else begin
      cor_ivalid_reg <= grant_any;
      if (grant_any) begin
        cor_ibb_reg <= bus.req_ibb[int'(grant_idx)*IQ_SIZE +: IQ_SIZE];
        cor_qbb_reg <= bus.req_qbb[int'(grant_idx)*IQ_SIZE +: IQ_SIZE];
        cor_idx_reg <= grant_idx;
        rr_ptr_reg  <= grant_idx;
      end
    end
  end

  assign bus.cor_ibb    = cor_ibb_reg;
  assign bus.cor_qbb    = cor_qbb_reg;
  assign bus.cor_ivalid = cor_ivalid_reg;

  // The last tag entry coincides with the core's cor_ovalid for the same sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_vld_reg <= '0;
      for (int k = 0; k < CORDIC_LAT; k++) tag_idx_reg[k] <= '0;
    end else begin
      tag_vld_reg[0] <= cor_ivalid_reg;
      tag_idx_reg[0] <= cor_idx_reg;
      for (int k = 1; k < CORDIC_LAT; k++) begin
        tag_vld_reg[k] <= tag_vld_reg[k-1];
        tag_idx_reg[k] <= tag_idx_reg[k-1];
      end
    end
  end

  assign last_vld = tag_vld_reg[CORDIC_LAT-1];
  assign last_idx = tag_idx_reg[CORDIC_LAT-1];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_route
      assign res_hit[gi] = bus.cor_ovalid & last_vld & (last_idx == idx_t'(gi));
      assign res_w_flat[gi*W_SIZE +: W_SIZE] = res_w_reg[gi];
    end
  endgenerate

  // Untagged results are dropped; any valid/tag disagreement latches err until reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_valid_reg <= '0;
      err_reg       <= 1'b0;
      for (int k = 0; k < NUM_REQ; k++) res_w_reg[k] <= '0;
    end else begin
      res_valid_reg <= res_hit;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (res_hit[k]) res_w_reg[k] <= bus.cor_wout;
      end
      if (bus.cor_ovalid != last_vld) err_reg <= 1'b1;
    end
  end

  assign bus.res_w     = res_w_flat;
  assign bus.res_valid = res_valid_reg;
  assign busy          = cor_ivalid_reg | (|tag_vld_reg);
  assign err           = err_reg;
endmodule

// File: tb/tb_zigbee_cordic_arbiter.sv
// Directed bench for zigbee_cordic_arbiter: arbitration vector table plus hand-written
// sequences for latency, fairness, enable drain, misalignment and mid-stream reset.
module tb_zigbee_cordic_arbiter;
  localparam int NUM_REQ    = 2;
  localparam int IQ_SIZE    = 5;
  localparam int W_SIZE     = 6;
  localparam int CORDIC_LAT = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic busy, err;
  logic inject = 1'b0;

  always #5 clk = ~clk;

  zigbee_cordic_arbiter_if #(.NUM_REQ(NUM_REQ), .IQ_SIZE(IQ_SIZE), .W_SIZE(W_SIZE)) bus ();

  zigbee_cordic_arbiter #(
    .NUM_REQ(NUM_REQ), .IQ_SIZE(IQ_SIZE), .W_SIZE(W_SIZE), .CORDIC_LAT(CORDIC_LAT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .bus(bus), .busy(busy), .err(err)
  );

  // Behavioural core: atan2 phase scaled so that pi maps to 2^(W_SIZE-1), then a delay line.
  logic [CORDIC_LAT-1:0] dl_vld;
  logic [W_SIZE-1:0]     dl_w [CORDIC_LAT];

  function automatic logic [W_SIZE-1:0] ref_phase(input logic signed [IQ_SIZE-1:0] i,
                                                  input logic signed [IQ_SIZE-1:0] q);
    real a;
    int  r;
    a = $atan2(real'(q), real'(i)) * real'(1 << (W_SIZE-1)) / 3.141592653589793;
    r = (a >= 0.0) ? $rtoi(a + 0.5) : -$rtoi(-a + 0.5);
    return W_SIZE'(r);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dl_vld <= '0;
      for (int k = 0; k < CORDIC_LAT; k++) dl_w[k] <= '0;
    end else begin
      dl_vld <= {dl_vld[CORDIC_LAT-2:0], bus.cor_ivalid};
      dl_w[0] <= ref_phase(bus.cor_ibb, bus.cor_qbb);
      for (int k = 1; k < CORDIC_LAT; k++) dl_w[k] <= dl_w[k-1];
    end
  end

  assign bus.cor_ovalid = dl_vld[CORDIC_LAT-1] | inject;
  assign bus.cor_wout   = dl_w[CORDIC_LAT-1];

  int n_cmp = 0;
  int n_bad = 0;

  int                 strobes [NUM_REQ];
  int                 bad_w;
  logic [W_SIZE-1:0]  exp_w [NUM_REQ];
  logic [NUM_REQ-1:0] rdy_s, rv_s;
  logic               civ_s, busy_s, err_s;
  logic [IQ_SIZE-1:0] cibb_s;
  logic [NUM_REQ*W_SIZE-1:0] resw_s;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // One clock: sample everything at the falling edge, then return 1 time unit past the rising edge.
  task automatic tick();
    @(negedge clk);
    rdy_s  = bus.req_ready;
    rv_s   = bus.res_valid;
    civ_s  = bus.cor_ivalid;
    cibb_s = bus.cor_ibb;
    busy_s = busy;
    err_s  = err;
    resw_s = bus.res_w;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (rv_s[k]) begin
        strobes[k]++;
        $display("result: req%0d w=%0d", k, $signed(resw_s[k*W_SIZE +: W_SIZE]));
        if (resw_s[k*W_SIZE +: W_SIZE] !== exp_w[k]) bad_w++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    for (int k = 0; k < NUM_REQ; k++) strobes[k] = 0;
    bad_w = 0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    bus.req_valid = '0;
    while (busy && n < 64) begin
      tick();
      n++;
    end
    tick();
    tick();
    check({name, " drain bounded"}, 32'(n < 64), 32'd1);
  endtask

  typedef struct {
    logic               en;
    logic [NUM_REQ-1:0] vld;
    logic [NUM_REQ-1:0] rdy;
  } arb_vec_t;

  arb_vec_t arb_tab [11];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int civ_cnt, civ_at, res_at, ibb_at1, bad_rdy, maxw0, maxw1, w0, w1, err_cnt;
    logic [NUM_REQ-1:0] res_first, exp_rdy;
    logic [W_SIZE-1:0]  resw0_at;
    logic busy5, busy6, prev_busy, busy_before, busy_at_last, r0v;

    arb_tab[0]  = '{1'b1, 2'b11, 2'b01};
    arb_tab[1]  = '{1'b1, 2'b11, 2'b10};
    arb_tab[2]  = '{1'b1, 2'b11, 2'b01};
    arb_tab[3]  = '{1'b1, 2'b10, 2'b10};
    arb_tab[4]  = '{1'b1, 2'b10, 2'b10};
    arb_tab[5]  = '{1'b1, 2'b01, 2'b01};
    arb_tab[6]  = '{1'b1, 2'b01, 2'b01};
    arb_tab[7]  = '{1'b0, 2'b11, 2'b00};
    arb_tab[8]  = '{1'b1, 2'b00, 2'b00};
    arb_tab[9]  = '{1'b1, 2'b11, 2'b10};
    arb_tab[10] = '{1'b1, 2'b11, 2'b01};

    // req0: I=10,Q=0 -> phase 0; req1: I=-10,Q=0 -> phase -32 (180 deg)
    bus.req_ibb   = {5'b10110, 5'd10};
    bus.req_qbb   = '0;
    exp_w[0]      = 6'd0;
    exp_w[1]      = 6'b100000;
    bus.req_valid = '1;
    enable        = 1'b1;
    clr();

    repeat (2) @(posedge clk);
    #1;
    check("reset req_ready",  32'(bus.req_ready),  32'd0);
    check("reset cor_ivalid", 32'(bus.cor_ivalid), 32'd0);
    check("reset cor_ibb",    32'(bus.cor_ibb),    32'd0);
    check("reset res_valid",  32'(bus.res_valid),  32'd0);
    check("reset res_w",      32'(bus.res_w),      32'd0);
    check("reset busy",       32'(busy),           32'd0);
    check("reset err",        32'(err),            32'd0);
    bus.req_valid = '0;
    reset_n = 1'b1;
    tick();

    // Arbitration table, starting from the reset pointer
    for (int v = 0; v < 11; v++) begin
      enable        = arb_tab[v].en;
      bus.req_valid = arb_tab[v].vld;
      tick();
      check($sformatf("arb[%0d] req_ready", v), 32'(rdy_s), 32'(arb_tab[v].rdy));
    end
    enable = 1'b1;
    drain("table");
    check("table req0 strobes", 32'(strobes[0]), 32'd5);
    check("table req1 strobes", 32'(strobes[1]), 32'd4);
    check("table phases",       32'(bad_w),      32'd0);
    check("table err",          32'(err_s),      32'd0);

    // Single request latency: cor_ivalid 1 cycle after transfer cycle, result 6 cycles after it
    clr();
    civ_cnt = 0; civ_at = -1; res_at = -1; ibb_at1 = 0;
    res_first = '0; resw0_at = '1; busy5 = 1'b0; busy6 = 1'b1;
    bus.req_valid = 2'b01;
    for (int k = 0; k <= 8; k++) begin
      tick();
      if (k == 0) check("single req_ready", 32'(rdy_s), 32'd1);
      bus.req_valid = '0;
      if (civ_s) begin civ_cnt++; civ_at = k; end
      if (k == 1) ibb_at1 = int'(cibb_s);
      if (rv_s != '0 && res_at < 0) begin
        res_at = k; res_first = rv_s; resw0_at = resw_s[W_SIZE-1:0];
      end
      if (k == 5) busy5 = busy_s;
      if (k == 6) busy6 = busy_s;
    end
    check("single cor_ivalid count", 32'(civ_cnt),   32'd1);
    check("single cor_ivalid cycle", 32'(civ_at),    32'd1);
    check("single cor_ibb",          32'(ibb_at1),   32'd10);
    check("single res cycle",        32'(res_at),    32'd6);
    check("single res_valid",        32'(res_first), 32'b01);
    check("single res_w0",           32'(resw0_at),  32'd0);
    check("single busy before",      32'(busy5),     32'd1);
    check("single busy after",       32'(busy6),     32'd0);
    check("single err",              32'(err_s),     32'd0);

    // Both requesters valid for 10 cycles: grants alternate, starting at req1 (pointer at 0)
    clr();
    bus.req_valid = 2'b11;
    for (int c = 0; c < 10; c++) begin
      tick();
      exp_rdy = (c % 2 == 0) ? 2'b10 : 2'b01;
      check($sformatf("alt[%0d] req_ready", c), 32'(rdy_s), 32'(exp_rdy));
    end
    drain("alt");
    check("alt req0 strobes", 32'(strobes[0]), 32'd5);
    check("alt req1 strobes", 32'(strobes[1]), 32'd5);
    check("alt phases",       32'(bad_w),      32'd0);

    // req1 always valid; req0 rests one cycle after each grant
    clr();
    maxw0 = 0; maxw1 = 0; w0 = 0; w1 = 0; r0v = 1'b1;
    for (int c = 0; c < 8; c++) begin
      bus.req_valid = {1'b1, r0v};
      tick();
      exp_rdy = (c % 2 == 0) ? 2'b10 : 2'b01;
      check($sformatf("fair[%0d] req_ready", c), 32'(rdy_s), 32'(exp_rdy));
      if (r0v && !rdy_s[0]) w0++; else w0 = 0;
      if (!rdy_s[1]) w1++; else w1 = 0;
      if (w0 > maxw0) maxw0 = w0;
      if (w1 > maxw1) maxw1 = w1;
      r0v = !rdy_s[0];
    end
    check("fair req0 max wait", 32'(maxw0 <= 1), 32'd1);
    check("fair req1 max wait", 32'(maxw1 <= 1), 32'd1);
    drain("fair");
    check("fair req0 strobes", 32'(strobes[0]), 32'd4);
    check("fair req1 strobes", 32'(strobes[1]), 32'd4);
    check("fair phases",       32'(bad_w),      32'd0);

    // Three transfers, then enable=0 while requests stay up
    clr();
    bus.req_valid = 2'b11;
    repeat (3) tick();
    enable = 1'b0;
    bad_rdy = 0; prev_busy = 1'b1; busy_before = 1'b0; busy_at_last = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (rdy_s != '0) bad_rdy++;
      if (rv_s != '0) begin busy_at_last = busy_s; busy_before = prev_busy; end
      prev_busy = busy_s;
    end
    check("drain no grants",          32'(bad_rdy),                 32'd0);
    check("drain strobes",            32'(strobes[0] + strobes[1]), 32'd3);
    check("drain busy before last",   32'(busy_before),             32'd1);
    check("drain busy at last",       32'(busy_at_last),            32'd0);
    check("drain phases",             32'(bad_w),                   32'd0);
    bus.req_valid = '0;
    enable = 1'b1;
    tick();

    // Core valid with empty tag pipe
    clr();
    tick();
    check("inject err before", 32'(err_s), 32'd0);
    inject = 1'b1;
    tick();
    inject = 1'b0;
    err_cnt = 0;
    repeat (4) begin
      tick();
      if (err_s) err_cnt++;
    end
    check("inject err sticky", 32'(err_cnt), 32'd4);
    check("inject no strobe",  32'(strobes[0] + strobes[1]), 32'd0);

    // Reset with two samples in flight
    clr();
    bus.req_valid = 2'b01;
    repeat (2) tick();
    bus.req_valid = '0;
    tick();
    bus.req_valid = 2'b11;
    reset_n = 1'b0;
    #1;
    check("rst busy",       32'(busy),           32'd0);
    check("rst err",        32'(err),            32'd0);
    check("rst cor_ivalid", 32'(bus.cor_ivalid), 32'd0);
    check("rst res_w",      32'(bus.res_w),      32'd0);
    check("rst res_valid",  32'(bus.res_valid),  32'd0);
    check("rst req_ready",  32'(bus.req_ready),  32'd0);
    bus.req_valid = '0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (10) tick();
    check("rst no stale strobes", 32'(strobes[0] + strobes[1]), 32'd0);
    check("rst err after",        32'(err_s),                   32'd0);

    // Fresh transfer after reset: I=0,Q=10 -> phase 16 (90 deg)
    bus.req_ibb[IQ_SIZE-1:0] = 5'd0;
    bus.req_qbb[IQ_SIZE-1:0] = 5'd10;
    exp_w[0] = 6'd16;
    bus.req_valid = 2'b01;
    tick();
    check("post rst req_ready", 32'(rdy_s), 32'b01);
    drain("post rst");
    check("post rst strobes", 32'(strobes[0]), 32'd1);
    check("post rst phase",   32'(bad_w),      32'd0);
    check("post rst err",     32'(err_s),      32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
